// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : calc_pkg
// Brief   : Shared widths, FSM state encoding and CombCalc opcode names.
// Revision: 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int CALC_W    = 4;
    localparam int CALC_OPW  = 3;
    localparam int CALC_CNTW = 8;

    localparam int              ST_W    = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_EXEC = 2'd1;
    localparam logic [ST_W-1:0] ST_RESP = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_NEG  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

endpackage
`default_nettype wire

// File: rtl/CombCalc.sv
`default_nettype none
// ============================================================================
// Module  : CombCalc
// Brief   : Combinational two's-complement calculator with signed overflow.
// Revision: 1.0 - initial release
// ============================================================================
module CombCalc
    import calc_pkg::*;
#(
    parameter int W = CALC_W
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] r,
    output logic         ovf
);

    always_comb begin
        r   = '0;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin
                r   = a + b;
                ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SUB: begin
                r   = a - b;
                ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NEG: begin
                r   = -a;
                ovf = (a == {1'b1, {(W-1){1'b0}}});
            end
            OP_SHL: begin
                r   = a << 1;
                ovf = a[W-1] ^ a[W-2];
            end
            default: r = a;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/calc_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : calc_arbiter
// Brief   : Round-robin sharing of one CombCalc between two requesters, with
//           registered responses and saturating per-requester overflow counts.
// Revision: 1.0 - initial release
// ============================================================================
module calc_arbiter
    import calc_pkg::*;
#(
    parameter int W    = CALC_W,
    parameter int OPW  = CALC_OPW,
    parameter int CNTW = CALC_CNTW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*OPW-1:0]  req_op,
    input  logic [2*W-1:0]    req_a,
    input  logic [2*W-1:0]    req_b,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [W-1:0]      rsp_r,
    output logic              rsp_ovf,
    input  logic              ovf_clr,
    output logic [CNTW-1:0]   ovf_cnt0,
    output logic [CNTW-1:0]   ovf_cnt1
);

    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_next;
    logic            r_last_grant;
    logic            r_grant;
    logic            w_grant;
    logic            w_req_hs;
    logic            w_rsp_hs;
    logic [OPW-1:0]  r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    w_r;
    logic            w_ovf;
    logic [1:0]      r_rsp_valid;
    logic [W-1:0]    r_rsp_r;
    logic            r_rsp_ovf;
    logic [CNTW-1:0] r_cnt0;
    logic [CNTW-1:0] r_cnt1;

    // A lone requester always wins; on contention the one not served last wins.
    assign w_grant  = (&req_valid) ? ~r_last_grant : req_valid[1];
    assign w_req_hs = (r_state == ST_IDLE) && (|req_valid);
    assign w_rsp_hs = (r_state == ST_RESP) && rsp_ready[r_grant];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req_hs) w_next = ST_EXEC;
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: if (w_rsp_hs) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (w_req_hs) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_rsp_valid  <= 2'b00;
            r_rsp_r      <= '0;
            r_rsp_ovf    <= 1'b0;
        end else begin
            if (w_req_hs) begin
                r_grant      <= w_grant;
                r_last_grant <= w_grant;
                r_op         <= w_grant ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
                r_a          <= w_grant ? req_a[2*W-1:W]      : req_a[W-1:0];
                r_b          <= w_grant ? req_b[2*W-1:W]      : req_b[W-1:0];
            end
            if (r_state == ST_EXEC) begin
                r_rsp_r     <= w_r;
                r_rsp_ovf   <= w_ovf;
                r_rsp_valid <= {r_grant, ~r_grant};
            end
            if (w_rsp_hs) begin
                r_rsp_valid <= 2'b00;
            end
        end
    end

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || ovf_clr) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_rsp_hs && r_rsp_ovf) begin
            if (!r_grant && (r_cnt0 != {CNTW{1'b1}})) r_cnt0 <= r_cnt0 + CNTW'(1);
            if ( r_grant && (r_cnt1 != {CNTW{1'b1}})) r_cnt1 <= r_cnt1 + CNTW'(1);
        end
    end

    CombCalc #(
        .W (W)
    ) u_calc (
        .op  (r_op),
        .a   (r_a),
        .b   (r_b),
        .r   (w_r),
        .ovf (w_ovf)
    );

    assign rsp_valid = r_rsp_valid;
    assign rsp_r     = r_rsp_r;
    assign rsp_ovf   = r_rsp_ovf;
    assign ovf_cnt0  = r_cnt0;
    assign ovf_cnt1  = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_calc_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_calc_arbiter
// Brief   : Transaction-level self-checking bench for calc_arbiter (CNTW=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_calc_arbiter;
    import calc_pkg::*;

    localparam int W    = 4;
    localparam int OPW  = 3;
    localparam int CNTW = 2;
    localparam int CMAX = (1 << CNTW) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [2*OPW-1:0] req_op = '0;
    logic [2*W-1:0]   req_a = '0;
    logic [2*W-1:0]   req_b = '0;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready = '0;
    logic [W-1:0]     rsp_r;
    logic             rsp_ovf;
    logic             ovf_clr = 1'b0;
    logic [CNTW-1:0]  ovf_cnt0;
    logic [CNTW-1:0]  ovf_cnt1;

    int n_chk = 0;
    int n_err = 0;
    bit m_last = 1'b1;
    int m_cnt[2] = '{0, 0};

    always #5 clk = ~clk;

    calc_arbiter #(.W(W), .OPW(OPW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_r     (rsp_r),
        .rsp_ovf   (rsp_ovf),
        .ovf_clr   (ovf_clr),
        .ovf_cnt0  (ovf_cnt0),
        .ovf_cnt1  (ovf_cnt1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic on plain signed integers.
    function automatic void ref_calc(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                     output logic [3:0] r, output logic ovf);
        int sa, sb, res;
        bit arith;
        sa = $signed(a);
        sb = $signed(b);
        res = 0;
        arith = 1'b1;
        r = 4'd0;
        case (op)
            OP_ADD:  res = sa + sb;
            OP_SUB:  res = sa - sb;
            OP_NEG:  res = -sa;
            OP_SHL:  res = sa * 2;
            OP_PASS: res = sa;
            OP_AND:  begin r = a & b; arith = 1'b0; end
            OP_OR:   begin r = a | b; arith = 1'b0; end
            default: begin r = a ^ b; arith = 1'b0; end
        endcase
        if (arith) begin
            r   = res[3:0];
            ovf = (res > 7) || (res < -8);
        end else begin
            ovf = 1'b0;
        end
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_last = 1'b1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    // Called and returns at one time unit after a rising edge with the DUT idle.
    task automatic do_op(input logic [1:0] valids,
                         input logic [2:0] op0, input logic [3:0] a0, input logic [3:0] b0,
                         input logic [2:0] op1, input logic [3:0] a1, input logic [3:0] b1,
                         input int delay, input bit clr);
        bit g;
        logic [1:0] oh;
        logic [3:0] er;
        logic eo;
        req_valid = valids;
        req_op = {op1, op0};
        req_a  = {a1, a0};
        req_b  = {b1, b0};
        rsp_ready = '0;
        ovf_clr = 1'b0;
        g  = (valids == 2'b11) ? ~m_last : valids[1];
        oh = g ? 2'b10 : 2'b01;
        if (g) ref_calc(op1, a1, b1, er, eo);
        else   ref_calc(op0, a0, b0, er, eo);
        @(negedge clk);
        check_eq("req_ready_grant", req_ready, oh);
        check_eq("rsp_valid_idle", rsp_valid, 2'b00);
        @(posedge clk);
        m_last = g;
        @(negedge clk);
        check_eq("req_ready_exec", req_ready, 2'b00);
        check_eq("rsp_valid_exec", rsp_valid, 2'b00);
        @(negedge clk);
        check_eq("rsp_valid_resp", rsp_valid, oh);
        check_eq("rsp_r", rsp_r, er);
        check_eq("rsp_ovf", rsp_ovf, eo);
        check_eq("req_ready_resp", req_ready, 2'b00);
        for (int i = 0; i < delay; i++) begin
            rsp_ready = g ? {1'b0, 1'($urandom)} : {1'($urandom), 1'b0};
            @(negedge clk);
            check_eq("rsp_valid_hold", rsp_valid, oh);
            check_eq("rsp_r_hold", rsp_r, er);
            check_eq("rsp_ovf_hold", rsp_ovf, eo);
            check_eq("req_ready_hold", req_ready, 2'b00);
        end
        rsp_ready = oh | (g ? {1'b0, 1'($urandom)} : {1'($urandom), 1'b0});
        ovf_clr = clr;
        @(posedge clk);
        #1;
        rsp_ready = '0;
        ovf_clr = 1'b0;
        if (clr) begin
            m_cnt[0] = 0;
            m_cnt[1] = 0;
        end else if (eo && m_cnt[g] < CMAX) begin
            m_cnt[g]++;
        end
        check_eq("rsp_valid_done", rsp_valid, 2'b00);
        check_eq("ovf_cnt0", ovf_cnt0, m_cnt[0]);
        check_eq("ovf_cnt1", ovf_cnt1, m_cnt[1]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset();
        check_eq("rst_rsp_valid", rsp_valid, 2'b00);
        check_eq("rst_rsp_r", rsp_r, 0);
        check_eq("rst_rsp_ovf", rsp_ovf, 0);
        check_eq("rst_cnt0", ovf_cnt0, 0);
        check_eq("rst_cnt1", ovf_cnt1, 0);
        check_eq("rst_req_ready", req_ready, 2'b00);

        do_op(2'b01, OP_ADD, 4'd3, 4'd2, OP_ADD, 4'd0, 4'd0, 0, 1'b0);
        do_op(2'b10, OP_ADD, 4'd0, 4'd0, OP_ADD, 4'd7, 4'd1, 1, 1'b0);

        apply_reset();
        for (int i = 0; i < 4; i++)
            do_op(2'b11, OP_SUB, 4'd5, 4'd3, OP_XOR, 4'd9, 4'd6, 0, 1'b0);

        do_op(2'b11, OP_SUB, 4'd2, 4'd7, OP_ADD, 4'd1, 4'd1, 5, 1'b0);
        do_op(2'b10, OP_SUB, 4'd2, 4'd7, OP_NEG, 4'd8, 4'd0, 0, 1'b0);

        for (int i = 0; i < 5; i++)
            do_op(2'b01, OP_ADD, 4'd7, 4'd7, OP_AND, 4'd0, 4'd0, i % 2, 1'b0);
        check_eq("sat_cnt0", ovf_cnt0, CMAX);
        do_op(2'b01, OP_ADD, 4'd7, 4'd7, OP_AND, 4'd0, 4'd0, 0, 1'b1);
        check_eq("clr_cnt0", ovf_cnt0, 0);

        for (int i = 0; i < 40; i++)
            do_op(2'($urandom_range(1, 3)),
                  3'($urandom), 4'($urandom), 4'($urandom),
                  3'($urandom), 4'($urandom), 4'($urandom),
                  int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));

        req_valid = 2'b01;
        req_op = {3'd0, OP_ADD};
        req_a  = {4'd0, 4'd7};
        req_b  = {4'd0, 4'd7};
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(posedge clk);
        #1;
        check_eq("pre_reset_resp", rsp_valid, 2'b01);
        reset = 1'b1;
        rsp_ready = 2'b01;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rsp_ready = 2'b00;
        m_last = 1'b1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        check_eq("rr_rsp_valid", rsp_valid, 2'b00);
        check_eq("rr_rsp_ovf", rsp_ovf, 0);
        check_eq("rr_cnt0", ovf_cnt0, 0);
        check_eq("rr_cnt1", ovf_cnt1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rr_no_resp", rsp_valid, 2'b00);
        end
        @(posedge clk);
        #1;
        do_op(2'b11, OP_SHL, 4'd5, 4'd0, OP_PASS, 4'd3, 4'd0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
